// File: rtl/seg_scan_pkg.sv
// Shared constants for the six-digit multiplexed clock display:
// active-low segment patterns (bits 0..6 = a..g, bit 7 = dp) and digit positions.
package seg_scan_pkg;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [2:0] POS_HOUR_H = 3'd0;
    localparam logic [2:0] POS_HOUR_L = 3'd1;
    localparam logic [2:0] POS_MIN_H  = 3'd2;
    localparam logic [2:0] POS_MIN_L  = 3'd3;
    localparam logic [2:0] POS_SEC_H  = 3'd4;
    localparam logic [2:0] POS_SEC_L  = 3'd5;

endpackage

// File: rtl/seg_scan_dec.sv
// seg7_dec: BCD digit to active-low 7-segment pattern, dp off; 10..15 show a dash.
// Ports: bcd [3:0] in, seg [7:0] out.
module seg7_dec
    import seg_scan_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg_scan.sv
// seg_scan: six-digit multiplexed display scanner with frame snapshot and blink.
// Ports: clk, rst_n, six BCD digits, run in; sel[5:0], seg[7:0] out (active-low).
module seg_scan
    import seg_scan_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 16,
    parameter int unsigned BLINK_FRAMES = 64,
    parameter bit          LZB          = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] hour_h,
    input  logic [3:0] hour_l,
    input  logic [3:0] min_h,
    input  logic [3:0] min_l,
    input  logic [3:0] sec_h,
    input  logic [3:0] sec_l,
    input  logic       run,
    output logic [5:0] sel,
    output logic [7:0] seg
);

    localparam logic [15:0] PRESC_MAX = 16'(SCAN_DIV - 1);
    localparam logic [15:0] FRM_MAX   = 16'(BLINK_FRAMES - 1);

    logic [15:0]      presc_q, presc_d;
    logic [2:0]       idx_q, idx_d;
    logic [15:0]      frm_q, frm_d;
    logic             blink_q, blink_d;
    // Element 0 holds hour_h, element 5 holds sec_l.
    logic [5:0][3:0]  snap_q, snap_d;
    logic [5:0]       sel_q, sel_d;
    logic [7:0]       seg_q, seg_d;

    logic             digit_tick;
    logic             frame_tick;
    logic [3:0]       cur_digit;
    logic [7:0]       dec_seg;

    seg7_dec u_dec (
        .bcd (cur_digit),
        .seg (dec_seg)
    );

    always_comb begin
        digit_tick = (presc_q == PRESC_MAX);
        frame_tick = digit_tick && (idx_q == POS_SEC_L);

        presc_d = digit_tick ? 16'd0 : presc_q + 16'd1;

        idx_d = idx_q;
        if (frame_tick)
            idx_d = POS_HOUR_H;
        else if (digit_tick)
            idx_d = idx_q + 3'd1;

        snap_d  = snap_q;
        frm_d   = frm_q;
        blink_d = blink_q;
        if (frame_tick) begin
            snap_d = {sec_l, sec_h, min_l, min_h, hour_l, hour_h};
            if (frm_q == FRM_MAX) begin
                frm_d   = 16'd0;
                blink_d = ~blink_q;
            end else begin
                frm_d = frm_q + 16'd1;
            end
        end

        cur_digit = snap_q[idx_q];
        sel_d     = ~(6'b100000 >> idx_q);

        seg_d = dec_seg;
        if (LZB && idx_q == POS_HOUR_H && cur_digit == 4'd0)
            seg_d = SEG_BLANK;
        // dp marks the hh.mm.ss separators only in the lit blink half.
        if (run && blink_q && (idx_q == POS_HOUR_L || idx_q == POS_MIN_L))
            seg_d[7] = 1'b0;
        // Paused: whole display flashes; run is live, not snapshotted.
        if (!run && blink_q)
            seg_d = SEG_BLANK;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= 16'd0;
            idx_q   <= POS_HOUR_H;
            frm_q   <= 16'd0;
            blink_q <= 1'b0;
            snap_q  <= '0;
            sel_q   <= 6'b111111;
            seg_q   <= SEG_BLANK;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            frm_q   <= frm_d;
            blink_q <= blink_d;
            snap_q  <= snap_d;
            sel_q   <= sel_d;
            seg_q   <= seg_d;
        end
    end

    assign sel = sel_q;
    assign seg = seg_q;

endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: scoreboard bench for seg_scan with SCAN_DIV=4, BLINK_FRAMES=2, LZB=1.
// Expected sel/seg are derived from the clock count since reset release.
module tb_seg_scan;

    logic       clk;
    logic       rst_n;
    logic [3:0] hour_h, hour_l, min_h, min_l, sec_h, sec_l;
    logic       run;
    logic [5:0] sel;
    logic [7:0] seg;

    int n_cmp;
    int n_bad;
    int k;
    logic [3:0] exp_snap [6];
    logic [13:0] sb_q [$];

    seg_scan #(
        .SCAN_DIV     (4),
        .BLINK_FRAMES (2),
        .LZB          (1'b1)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .hour_h (hour_h),
        .hour_l (hour_l),
        .min_h  (min_h),
        .min_l  (min_l),
        .sec_h  (sec_h),
        .sec_l  (sec_l),
        .run    (run),
        .sel    (sel),
        .seg    (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s k=%0d got=%0h exp=%0h", tag, k, got, exp);
        end
    endtask

    function automatic logic [7:0] pat(input logic [3:0] d);
        case (d)
            4'd0: return 8'b1100_0000;
            4'd1: return 8'b1111_1001;
            4'd2: return 8'b1010_0100;
            4'd3: return 8'b1011_0000;
            4'd4: return 8'b1001_1001;
            4'd5: return 8'b1001_0010;
            4'd6: return 8'b1000_0010;
            4'd7: return 8'b1111_1000;
            4'd8: return 8'b1000_0000;
            4'd9: return 8'b1001_0000;
            default: return 8'b1011_1111;
        endcase
    endfunction

    task automatic clear_snap();
        for (int i = 0; i < 6; i++) exp_snap[i] = 4'd0;
    endtask

    // Push expectation for the coming edge, clock it, pop and compare.
    task automatic step();
        int idx, frm, blink;
        logic [7:0] s;
        logic [5:0] sl;
        logic [13:0] e;
        idx   = (k / 4) % 6;
        frm   = k / 24;
        blink = (frm / 2) % 2;
        sl    = ~(6'b100000 >> idx);
        if (idx == 0 && exp_snap[0] == 4'd0) s = 8'hFF;
        else s = pat(exp_snap[idx]);
        if (run && blink == 1 && (idx == 1 || idx == 3)) s[7] = 1'b0;
        if (!run && blink == 1) s = 8'hFF;
        sb_q.push_back({sl, s});
        if (k % 24 == 23) begin
            exp_snap[0] = hour_h; exp_snap[1] = hour_l;
            exp_snap[2] = min_h;  exp_snap[3] = min_l;
            exp_snap[4] = sec_h;  exp_snap[5] = sec_l;
        end
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check("sel", 32'(sel), 32'(e[13:8]));
            check("seg", 32'(seg), 32'(e[7:0]));
        end
        k++;
    endtask

    task automatic set_time(input logic [3:0] a, b, c, d, e, f);
        hour_h = a; hour_l = b; min_h = c; min_l = d; sec_h = e; sec_l = f;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        k     = 0;
        clear_snap();
        rst_n = 1'b0;
        run   = 1'b1;
        set_time(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
        repeat (3) @(posedge clk);
        #1;
        check("rst_sel", 32'(sel), 32'h3F);
        check("rst_seg", 32'(seg), 32'hFF);
        @(negedge clk);
        rst_n = 1'b1;

        // 12:34:56 running; change to :57 mid-frame 2
        for (int i = 0; i < 96; i++) begin
            if (k == 60) sec_l = 4'd7;
            step();
        end

        // leading-zero hour 09
        set_time(4'd0, 4'd9, 4'd5, 4'd9, 4'd0, 4'd1);
        for (int i = 0; i < 72; i++) step();

        // paused with an out-of-range sec_l digit
        run = 1'b0;
        set_time(4'd2, 4'd3, 4'd5, 4'd9, 4'd4, 4'hC);
        for (int i = 0; i < 120; i++) step();
        run = 1'b1;

        // mid-frame async reset during index 3
        for (int i = 0; i < 24 && ((k / 4) % 6) != 3; i++) step();
        check("idx3_reached", 32'((k / 4) % 6), 32'd3);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_sel", 32'(sel), 32'h3F);
        check("arst_seg", 32'(seg), 32'hFF);
        @(posedge clk);
        #1;
        check("arst_hold_sel", 32'(sel), 32'h3F);
        check("arst_hold_seg", 32'(seg), 32'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        clear_snap();
        for (int i = 0; i < 60; i++) step();

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seg_scan.md
SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 Parameter SCAN_DIV, default 16: clocks each digit stays selected; legal range 2..65535.
REQ-002 Parameter BLINK_FRAMES, default 64: full 6-digit scan frames per blink half-period; legal range 1..65535.
REQ-003 Parameter LZB, default 1: 1 blanks a leading zero on hour_h.
REQ-004 clk  input  1  single system clock, rising edge.
REQ-005 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-006 hour_h, hour_l, min_h, min_l, sec_h, sec_l  input  4 each  BCD time digits from the time counters.
REQ-007 run  input  1  1 = time counting, 0 = paused.
REQ-008 sel  output  6  digit enables, active-low, one-hot-low; bit 5 = hour_h (leftmost) ... bit 0 = sec_l.
REQ-009 seg  output  8  segments, active-low; bits 0..6 = a..g, bit 7 = dp.

Function
REQ-010 A prescaler shall count 0..SCAN_DIV-1 and wrap; the wrap cycle is the digit tick.
REQ-011 Digit index shall count 0..5 (0 = hour_h, 5 = sec_l), advance on each digit tick, and wrap 5 -> 0.
REQ-012 The 5 -> 0 wrap is the frame tick; on it all six input digits shall be captured into a snapshot register, and display shall use only the snapshot (no tearing within a frame).
REQ-013 The first frame after reset shall display the reset snapshot (all zeros); live inputs appear from the second frame onward.
REQ-014 A frame counter shall count 0..BLINK_FRAMES-1 on frame ticks; blink phase shall toggle on its wrap.
REQ-015 sel and seg shall be registered, reflecting the current index and snapshot with exactly one clock of latency.
REQ-016 Decode: 0..9 shall give standard 7-segment patterns; 10..15 shall show a dash (g only lit).
REQ-017 When LZB=1 and snapshot hour_h = 0, that digit shall be blank (seg = 8'hFF) while sel still enables it.
REQ-018 When run=1, dp shall be lit on hour_l and min_l only while blink phase = 1; dp shall be off on all other digits.
REQ-019 When run=0, all segments including dp shall be blanked while blink phase = 1; when blink phase = 0, digits shall show normally with dp off.
REQ-020 run shall be sampled directly, not snapshotted, so pausing takes effect on the next clock.
REQ-021 Exactly one sel bit shall be low on every cycle after the first post-reset clock edge.

Reset
REQ-022 While rst_n = 0: sel = 6'b111111, seg = 8'hFF, prescaler = 0, index = 0, frame counter = 0, blink phase = 0, snapshot = all zeros.
REQ-023 After release, the first clock edge shall drive sel = 6'b011111 with the hour_h pattern.
REQ-024 Reset asserted mid-frame shall return every register to its REQ-022 value immediately, with no completion of the frame.

Structure
REQ-025 Segment pattern constants (digits 0..9, dash, blank) and digit-position constants shall live in a shared package.
REQ-026 BCD-to-segment decode shall be a separate combinational sub-module, seg7_dec, instantiated once on the selected snapshot digit.

Verification (SCAN_DIV=4, BLINK_FRAMES=2, LZB=1)
REQ-027 Reset release, inputs 12:34:56, run=1 -> sel walks 011111, 101111, ... 111110, 4 clocks each; frame 1 shows blank hour_h and 0s; frame 2 shows 1,2,3,4,5,6.
REQ-028 Change inputs from 12:34:56 to 12:34:57 mid-frame -> the current frame still shows 6 on sec_l; the next frame shows 7.
REQ-029 hour_h=0, hour_l=9 -> hour_h digit seg = 8'hFF with sel bit 5 low; hour_l shows the 9 pattern.
REQ-030 run=1 over 4 frames -> dp on hour_l and min_l off for 2 frames, then on for 2 frames; never on other digits.
REQ-031 run=0 -> seg = 8'hFF on all digits for 2 of every 4 frames, normal digits otherwise; sec_l = 4'hC shows dash (seg = 8'b1011_1111).
REQ-032 rst_n pulsed low during index 3 -> sel = 6'b111111 and seg = 8'hFF asynchronously; restart at index 0 with a zero snapshot.
